lcd_leitura_crc: RTL and testbench

Reads back the 12-character CRC result line that the LCD writer places in HD44780 DDRAM and decodes it into a 32-bit CRC value plus the test-error flag. The line holds 8 hex digits, least-significant nibble first, then a space, then "01" and a final '2' (pass) or '3' (error). The block sits beside the LCD writer on the shared character-LCD bus. It performs HD44780 read cycles (RW=1) with busy-flag polling, so that on-board self-test can confirm what was displayed.

---
 rtl/lcd_leitura_crc_pkg.sv | 51 +++++
 rtl/lcd_leitura_crc_bus_ciclo.sv | 66 ++++++
 rtl/lcd_leitura_crc.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_leitura_crc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_leitura_crc_pkg.sv
// Shared types and constants for the HD44780 CRC line read-back block.
// Holds the FSM state encoding, LCD command/ASCII constants and the hex decoder.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BF_POLL,
        ST_SET_ADDR,
        ST_READ_CHAR,
        ST_DISPATCH,
        ST_DONE
    } lcd_state_t;

    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam int         BF_BIT        = 7;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [7:0] ASCII_2     = 8'h32;
    localparam logic [7:0] ASCII_3     = 8'h33;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_F     = 8'h46;

    localparam logic [3:0] IDX_SPACE = 4'd8;
    localparam logic [3:0] IDX_ZERO  = 4'd9;
    localparam logic [3:0] IDX_ONE   = 4'd10;
    localparam logic [3:0] IDX_LAST  = 4'd11;

    typedef struct packed {
        logic       valid;
        logic [3:0] nib;
    } hex_dec_t;

    // Uppercase hex only; anything else decodes to nibble 0 with valid=0.
    function automatic hex_dec_t hex_to_nibble(input logic [7:0] c);
        hex_dec_t r;
        r.valid = 1'b1;
        r.nib   = 4'h0;
        if (c >= ASCII_0 && c <= ASCII_9) begin
            r.nib = c[3:0];
        end else if (c >= ASCII_A && c <= ASCII_F) begin
            r.nib = c[3:0] + 4'd9;
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_leitura_crc_bus_ciclo.sv
// One HD44780 bus cycle: T_AS setup, T_PW enable pulse, T_H hold, then a one-clock ack.
// Control lines follow req so they are stable for the whole cycle; read data is
// captured on the last enable-high clock.
module lcd_bus_ciclo #(
    parameter int T_AS = 2,
    parameter int T_PW = 12,
    parameter int T_H  = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] wdata,
    input  logic [7:0] data_in,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe
);

    localparam int T_TOTAL = T_AS + T_PW + T_H;
    localparam int CNT_W   = $clog2(T_TOTAL);

    localparam logic [CNT_W-1:0] CNT_EN_ON  = CNT_W'(T_AS);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(T_AS + T_PW - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(T_TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rdata_q, rdata_d;

    always_comb begin
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        if (!req || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (req && rw && cnt_q == CNT_SAMPLE) begin
            rdata_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack          = req && (cnt_q == CNT_LAST);
    assign rdata        = rdata_q;
    assign lcd_rs       = req && rs;
    assign lcd_rw       = req && rw;
    assign lcd_en       = req && (cnt_q >= CNT_EN_ON) && (cnt_q <= CNT_SAMPLE);
    assign lcd_data_oe  = req && !rw;
    assign lcd_data_out = lcd_data_oe ? wdata : 8'h00;

endmodule

// File: rtl/lcd_leitura_crc.sv
// Reads the 12-character CRC result line back from HD44780 DDRAM and decodes it.
// Optional busy-flag timeout is enabled with `define LCD_LEITURA_TIMEOUT_EN.
module lcd_leitura_crc
    import lcd_pkg::*;
#(
    parameter int         T_AS         = 2,
    parameter int         T_PW         = 12,
    parameter int         T_H          = 12,
    parameter logic [6:0] START_ADDR   = 7'h00,
    parameter int         BUSY_TIMEOUT = 1000
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [7:0]  LCD_DATA_IN,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic [7:0]  LCD_DATA_OUT,
    output logic        LCD_DATA_OE,
    output logic        busy,
    output logic        done,
    output logic [31:0] crc_out,
    output logic        crc_valid,
    output logic        teste_erro,
    output logic        fmt_err,
    output logic        timeout
);

    lcd_state_t  state_q, state_d;
    lcd_state_t  op_q, op_d;
    logic [3:0]  k_q, k_d;
    logic        addr_set_q, addr_set_d;
    logic [31:0] crc_q, crc_d;
    logic        crc_valid_q, crc_valid_d;
    logic        teste_erro_q, teste_erro_d;
    logic        fmt_err_q, fmt_err_d;

`ifdef LCD_LEITURA_TIMEOUT_EN
    localparam int POLL_W = $clog2(BUSY_TIMEOUT + 1);
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    logic       bus_req;
    logic       bus_ack;
    logic [7:0] rdata;
    hex_dec_t   dec;
    logic       char_ok;

    assign bus_req = (state_q == ST_BF_POLL) || (state_q == ST_SET_ADDR) ||
                     (state_q == ST_READ_CHAR);

    lcd_bus_ciclo #(
        .T_AS (T_AS),
        .T_PW (T_PW),
        .T_H  (T_H)
    ) u_bus (
        .clk          (Clock),
        .rst_n        (Reset_n),
        .req          (bus_req),
        .rs           (state_q == ST_READ_CHAR),
        .rw           (state_q != ST_SET_ADDR),
        .wdata        (CMD_SET_DDRAM | {1'b0, START_ADDR}),
        .data_in      (LCD_DATA_IN),
        .ack          (bus_ack),
        .rdata        (rdata),
        .lcd_rs       (LCD_RS),
        .lcd_rw       (LCD_RW),
        .lcd_en       (LCD_EN),
        .lcd_data_out (LCD_DATA_OUT),
        .lcd_data_oe  (LCD_DATA_OE)
    );

    assign dec = hex_to_nibble(rdata);

    always_comb begin
        case (k_q)
            IDX_SPACE: char_ok = (rdata == ASCII_SPACE);
            IDX_ZERO:  char_ok = (rdata == ASCII_0);
            IDX_ONE:   char_ok = (rdata == ASCII_1);
            IDX_LAST:  char_ok = (rdata == ASCII_2) || (rdata == ASCII_3);
            default:   char_ok = dec.valid;
        endcase
    end

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        k_d          = k_q;
        addr_set_d   = addr_set_q;
        crc_d        = crc_q;
        crc_valid_d  = crc_valid_q;
        teste_erro_d = teste_erro_q;
        fmt_err_d    = fmt_err_q;
`ifdef LCD_LEITURA_TIMEOUT_EN
        poll_cnt_d   = poll_cnt_q;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    crc_d        = '0;
                    crc_valid_d  = 1'b0;
                    teste_erro_d = 1'b0;
                    fmt_err_d    = 1'b0;
                    k_d          = '0;
                    addr_set_d   = 1'b0;
`ifdef LCD_LEITURA_TIMEOUT_EN
                    poll_cnt_d   = '0;
                    timeout_d    = 1'b0;
`endif
                    state_d      = ST_BF_POLL;
                end
            end
            ST_BF_POLL, ST_SET_ADDR, ST_READ_CHAR: begin
                if (bus_ack) begin
                    op_d    = state_q;
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                case (op_q)
                    ST_BF_POLL: begin
                        if (rdata[BF_BIT]) begin
`ifdef LCD_LEITURA_TIMEOUT_EN
                            if (poll_cnt_q == POLL_W'(BUSY_TIMEOUT - 1)) begin
                                timeout_d   = 1'b1;
                                crc_d       = '0;
                                crc_valid_d = 1'b0;
                                state_d     = ST_DONE;
                            end else begin
                                poll_cnt_d = poll_cnt_q + POLL_W'(1);
                                state_d    = ST_BF_POLL;
                            end
`else
                            state_d = ST_BF_POLL;
`endif
                        end else begin
`ifdef LCD_LEITURA_TIMEOUT_EN
                            poll_cnt_d = '0;
`endif
                            state_d = addr_set_q ? ST_READ_CHAR : ST_SET_ADDR;
                        end
                    end
                    ST_SET_ADDR: begin
                        addr_set_d = 1'b1;
                        state_d    = ST_BF_POLL;
                    end
                    ST_READ_CHAR: begin
                        fmt_err_d = fmt_err_q | ~char_ok;
                        if (!k_q[3]) begin
                            crc_d[{k_q[2:0], 2'b00} +: 4] = dec.nib;
                        end
                        if (k_q == IDX_LAST) begin
                            teste_erro_d = (rdata == ASCII_3);
                            crc_valid_d  = char_ok & ~fmt_err_q;
                            state_d      = ST_DONE;
                        end else begin
                            k_d     = k_q + 4'd1;
                            state_d = ST_BF_POLL;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: reset is synchronous; Reset_n is only looked at on the clock edge.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            op_q         <= ST_IDLE;
            k_q          <= '0;
            addr_set_q   <= 1'b0;
            crc_q        <= '0;
            crc_valid_q  <= 1'b0;
            teste_erro_q <= 1'b0;
            fmt_err_q    <= 1'b0;
`ifdef LCD_LEITURA_TIMEOUT_EN
            poll_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            k_q          <= k_d;
            addr_set_q   <= addr_set_d;
            crc_q        <= crc_d;
            crc_valid_q  <= crc_valid_d;
            teste_erro_q <= teste_erro_d;
            fmt_err_q    <= fmt_err_d;
`ifdef LCD_LEITURA_TIMEOUT_EN
            poll_cnt_q   <= poll_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign crc_out    = crc_q;
    assign crc_valid  = crc_valid_q;
    assign teste_erro = teste_erro_q;
    assign fmt_err    = fmt_err_q;
`ifdef LCD_LEITURA_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_leitura_crc.sv
// Scoreboard bench for lcd_leitura_crc with a behavioural HD44780 (DDRAM, BF, auto-increment).
// Build with LCD_LEITURA_TIMEOUT_EN defined to exercise the busy-flag timeout.
module tb_lcd_leitura_crc;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        start;
    logic [7:0]  LCD_DATA_IN;
    logic        LCD_RS, LCD_RW, LCD_EN, LCD_DATA_OE;
    logic [7:0]  LCD_DATA_OUT;
    logic        busy, done, crc_valid, teste_erro, fmt_err, timeout;
    logic [31:0] crc_out;

    always #5 Clock = ~Clock;

    lcd_leitura_crc #(.BUSY_TIMEOUT(4)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .start        (start),
        .LCD_DATA_IN  (LCD_DATA_IN),
        .LCD_RS       (LCD_RS),
        .LCD_RW       (LCD_RW),
        .LCD_EN       (LCD_EN),
        .LCD_DATA_OUT (LCD_DATA_OUT),
        .LCD_DATA_OE  (LCD_DATA_OE),
        .busy         (busy),
        .done         (done),
        .crc_out      (crc_out),
        .crc_valid    (crc_valid),
        .teste_erro   (teste_erro),
        .fmt_err      (fmt_err),
        .timeout      (timeout)
    );

    // ---------------- behavioural LCD ----------------
    logic [7:0] ddram [0:127];
    logic [6:0] lcd_addr;
    int         reads_done;
    int         stall_left;
    int         stall_at_cfg;
    int         stall_cfg;
    logic       model_load;
    logic       en_last;
    logic       bf_now;

    assign bf_now      = (stall_left > 0) && (reads_done == stall_at_cfg);
    assign LCD_DATA_IN = LCD_RS ? ddram[lcd_addr] : {bf_now, lcd_addr};

    always @(posedge Clock) begin
        if (model_load) begin
            lcd_addr   <= 7'h00;
            reads_done <= 0;
            stall_left <= stall_cfg;
            en_last    <= 1'b0;
        end else begin
            en_last <= LCD_EN;
            if (en_last && !LCD_EN) begin
                if (LCD_RS && LCD_RW) begin
                    lcd_addr   <= lcd_addr + 7'd1;
                    reads_done <= reads_done + 1;
                end else if (!LCD_RS && LCD_RW) begin
                    if (bf_now) stall_left <= stall_left - 1;
                end else if (LCD_DATA_OE && LCD_DATA_OUT[7]) begin
                    lcd_addr <= LCD_DATA_OUT[6:0];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] crc;
        logic        valid;
        logic        teste;
        logic        fmt;
        logic        tmo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (Reset_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("crc_out",    crc_out,           mon_e.crc);
                check("crc_valid",  32'(crc_valid),    32'(mon_e.valid));
                check("teste_erro", 32'(teste_erro),   32'(mon_e.teste));
                check("fmt_err",    32'(fmt_err),      32'(mon_e.fmt));
                check("timeout",    32'(timeout),      32'(mon_e.tmo));
                check("busy_at_done", 32'(busy),       32'd0);
                check("done_cycle", 32'(cyc - start_cyc), 32'(mon_e.cyc));
            end
        end
    end

    // Bus invariants: OE and RW exclusive; RS/RW/OE frozen while EN is high.
    logic p_en = 1'b0, p_rs = 1'b0, p_rw = 1'b0, p_oe = 1'b0;
    always @(negedge Clock) begin
        if (LCD_DATA_OE && LCD_RW) check("oe_rw_exclusive", 32'd1, 32'd0);
        if (LCD_EN && p_en)
            check("bus_stable_en", {29'd0, LCD_RS, LCD_RW, LCD_DATA_OE}, {29'd0, p_rs, p_rw, p_oe});
        p_en = LCD_EN;
        p_rs = LCD_RS;
        p_rw = LCD_RW;
        p_oe = LCD_DATA_OE;
    end

    // ---------------- stimulus ----------------
    task automatic prep(input string line, input int at, input int stall);
        for (int i = 0; i < 12; i++) ddram[i] = line[i];
        stall_at_cfg = at;
        stall_cfg    = stall;
        model_load   = 1'b1;
        @(negedge Clock);
        model_load   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] crc, input logic valid, input logic teste,
                         input logic fmt, input logic tmo, input int dcyc, input bit push);
        exp_t e;
        e.crc = crc; e.valid = valid; e.teste = teste; e.fmt = fmt; e.tmo = tmo; e.cyc = dcyc;
        if (push) exp_q.push_back(e);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge Clock);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge Clock);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy",       32'(busy),         32'd0);
        check("rst_done",       32'(done),         32'd0);
        check("rst_crc_out",    crc_out,           32'd0);
        check("rst_crc_valid",  32'(crc_valid),    32'd0);
        check("rst_teste_erro", 32'(teste_erro),   32'd0);
        check("rst_fmt_err",    32'(fmt_err),      32'd0);
        check("rst_timeout",    32'(timeout),      32'd0);
        check("rst_lcd_ctrl",   {28'd0, LCD_RS, LCD_RW, LCD_EN, LCD_DATA_OE}, 32'd0);
        check("rst_lcd_data",   32'(LCD_DATA_OUT), 32'd0);
    endtask

    initial begin
        Reset_n      = 1'b0;
        start        = 1'b0;
        model_load   = 1'b0;
        stall_at_cfg = 0;
        stall_cfg    = 0;
        for (int i = 0; i < 128; i++) ddram[i] = 8'h20;
        repeat (3) @(negedge Clock);
        check_reset_outputs();
        Reset_n = 1'b1;
        @(negedge Clock);

        // Nominal pass line.
        prep("FEDCBA98 012", 0, 0);
        issue(32'h89ABCDEF, 1'b1, 1'b0, 1'b0, 1'b0, 703, 1'b1);
        wait_drain(1500);

        // Error flag line; start pulsed during done must be ignored.
        prep("10000000 013", 0, 0);
        issue(32'h00000001, 1'b1, 1'b1, 1'b0, 1'b0, 703, 1'b1);
        while (cyc - start_cyc < 703) @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        check("start_at_done_ignored", 32'(busy), 32'd0);
        check("result_hold_teste", 32'(teste_erro), 32'd1);
        wait_drain(10);

        // Malformed hex digit at position 3.
        prep("FEDgBA98 012", 0, 0);
        issue(32'h89AB0DEF, 1'b0, 1'b0, 1'b1, 1'b0, 703, 1'b1);
        wait_drain(1500);

        // Five busy polls before character 4.
        prep("FEDCBA98 012", 4, 5);
        issue(32'h89ABCDEF, 1'b1, 1'b0, 1'b0, 1'b0, 838, 1'b1);
        wait_drain(2000);

        // Reset mid-transaction, then a fresh read.
        prep("10000000 013", 0, 0);
        issue(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        while (cyc - start_cyc < 300) @(negedge Clock);
        Reset_n = 1'b0;
        @(negedge Clock);
        check_reset_outputs();
        Reset_n = 1'b1;
        prep("FEDCBA98 013", 0, 0);
        issue(32'h89ABCDEF, 1'b1, 1'b1, 1'b0, 1'b0, 703, 1'b1);
        wait_drain(1500);

        // Busy flag stuck high.
        prep("FEDCBA98 012", 0, 1000000);
`ifdef LCD_LEITURA_TIMEOUT_EN
        issue(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 109, 1'b1);
        wait_drain(500);
`else
        issue(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (3000) @(negedge Clock);
        check("busy_stuck_bf", 32'(busy), 32'd1);
        check("no_timeout_flag", 32'(timeout), 32'd0);
        Reset_n = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        check("busy_after_abort", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
